pipelined_addsub: RTL and testbench

// Parametrised, pipelined add/subtract unit with carry-in and condition flags (C, V, N, Z).
// It is the datapath successor to the 8-bit ripple adder for the wider ALU.

---
 rtl/pipelined_addsub.sv | 144 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit with carry-in and C/V/N/Z flags.
// The operands are split into SEG segments of W bits each. Stage k resolves the
// carry chain of segment k only, so the critical path is one W-bit adder.
// A valid/ready handshake with a single global advance signal gives full
// backpressure: either every stage shifts or every stage holds.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic [1:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z
);

    localparam int W   = WIDTH / SEG;
    // Depth of the intermediate (non-final) stage registers; kept >= 1 so the
    // arrays stay legal when SEG = 1 collapses the pipe to a single adder.
    localparam int MID = (SEG > 1) ? SEG - 1 : 1;

    // Global advance: the pipe moves whenever the output slot is free or drained.
    logic adv;

    // Effective operands: subtraction is A + ~B + carry.
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    // Per-stage valid and segment carry-out.
    logic             v_reg  [SEG];
    logic             c_reg  [SEG];

    // Intermediate stages carry one word that holds the finished low result
    // segments together with the not-yet-added high segments of A, plus the
    // full effective B word.
    logic [WIDTH-1:0] ya_reg [MID];
    logic [WIDTH-1:0] b_reg  [MID];

    // Final stage result and flags.
    logic [WIDTH-1:0] y_reg;
    logic             vf_reg;
    logic             n_reg;
    logic             z_reg;

    assign adv      = !v_reg[SEG-1] || out_ready;
    assign in_ready = adv;

    // OP[1] selects subtraction (invert B); OP[0] selects the external carry-in.
    assign b_eff = OP[1] ? ~B : B;
    assign cin0  = OP[0] ? CI : OP[1];

    genvar gi;
    generate
        for (gi = 0; gi < SEG; gi++) begin : gen_stage
            logic             src_v;
            logic             src_c;
            logic [WIDTH-1:0] src_ya;
            logic [WIDTH-1:0] src_b;
            logic [WIDTH-1:0] ya_next;
            logic [W:0]       seg_sum;

            if (gi == 0) begin : g_src_in
                assign src_v  = in_valid;
                assign src_c  = cin0;
                assign src_ya = A;
                assign src_b  = b_eff;
            end else begin : g_src_prev
                assign src_v  = v_reg[gi-1];
                assign src_c  = c_reg[gi-1];
                assign src_ya = ya_reg[gi-1];
                assign src_b  = b_reg[gi-1];
            end

            // One segment of the ripple: A segment + Beff segment + incoming carry.
            assign seg_sum = {1'b0, src_ya[gi*W +: W]} + {1'b0, src_b[gi*W +: W]}
                           + {{W{1'b0}}, src_c};

            // Replace this segment of A with its sum; other segments pass through.
            always_comb begin
                ya_next               = src_ya;
                ya_next[gi*W +: W]    = seg_sum[W-1:0];
            end

            // Stage valid and segment carry advance together with the pipe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_reg[gi] <= 1'b0;
                    c_reg[gi] <= 1'b0;
                end else if (adv) begin
                    v_reg[gi] <= src_v;
                    c_reg[gi] <= seg_sum[W];
                end
            end

            if (gi < SEG - 1) begin : g_mid
                // Partial result word and effective B move to the next stage.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ya_reg[gi] <= '0;
                        b_reg[gi]  <= '0;
                    end else if (adv) begin
                        ya_reg[gi] <= ya_next;
                        b_reg[gi]  <= src_b;
                    end
                end
            end else begin : g_last
                // Final stage: the word is now the full result; derive the flags.
                // src_ya[WIDTH-1] is still A's MSB since the top segment is added here.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        y_reg  <= '0;
                        vf_reg <= 1'b0;
                        n_reg  <= 1'b0;
                        z_reg  <= 1'b0;
                    end else if (adv) begin
                        y_reg  <= ya_next;
                        vf_reg <= (src_ya[WIDTH-1] == src_b[WIDTH-1])
                               && (ya_next[WIDTH-1] != src_ya[WIDTH-1]);
                        n_reg  <= ya_next[WIDTH-1];
                        z_reg  <= (ya_next == '0);
                    end
                end
            end
        end
    endgenerate

    assign out_valid = v_reg[SEG-1];
    assign Y         = y_reg;
    assign C         = c_reg[SEG-1];
    assign V         = vf_reg;
    assign N         = n_reg;
    assign Z         = z_reg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: a 16-bit/4-segment instance and an
// 8-bit/1-segment instance, checked against a plain-arithmetic reference model.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 16-bit, 4-segment instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, y;
    logic        ci, c, v, n, z;
    logic [1:0]  op;

    // 8-bit, 1-segment instance
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0]  s_a, s_b, s_y;
    logic        s_ci, s_c, s_v, s_n, s_z;
    logic [1:0]  s_op;

    pipelined_addsub #(.WIDTH(16), .SEG(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .CI(ci), .OP(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .Y(y), .C(c), .V(v), .N(n), .Z(z)
    );

    pipelined_addsub #(.WIDTH(8), .SEG(1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .A(s_a), .B(s_b), .CI(s_ci), .OP(s_op),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .Y(s_y), .C(s_c), .V(s_v), .N(s_n), .Z(s_z)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int n_out16 = 0;
    int n_out8  = 0;

    logic [35:0] q16[$];
    logic [35:0] q8[$];
    int          q8_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: integer arithmetic on the effective operands; signed overflow
    // taken from whether the true signed sum leaves the representable range.
    function automatic logic [35:0] model(input int w, input logic [1:0] opc,
                                         input logic [31:0] ua32, input logic [31:0] ub32,
                                         input logic cin);
        longint mask, ua, ub, sum, half, sa, sb, s, carry;
        logic [31:0] yv;
        logic cv, vv;
        mask  = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        ua    = longint'(ua32) & mask;
        ub    = opc[1] ? (longint'(~ub32) & mask) : (longint'(ub32) & mask);
        case (opc)
            2'b00:   carry = 0;
            2'b10:   carry = 1;
            default: carry = cin ? 1 : 0;
        endcase
        sum = ua + ub + carry;
        yv  = 32'(sum & mask);
        cv  = ((sum >> w) & 1) != 0;
        sa  = (ua >= half) ? ua - (longint'(1) << w) : ua;
        sb  = (ub >= half) ? ub - (longint'(1) << w) : ub;
        s   = sa + sb + carry;
        vv  = (s >= half) || (s < -half);
        return {yv, cv, vv, yv[w-1], (yv == 32'h0)};
    endfunction

    // Compare process for the 16-bit instance: scoreboard, handshake rule, hold rule.
    logic        prev_stall16 = 1'b0;
    logic [19:0] prev_out16   = '0;
    always @(negedge clk) begin
        logic [35:0] e;
        if (!rst_n) begin
            q16.delete();
            prev_stall16 = 1'b0;
        end else begin
            check("in_ready16", {35'h0, in_ready}, {35'h0, (!out_valid || out_ready)});
            if (prev_stall16)
                check("hold16", {16'h0, y, c, v, n, z}, {16'h0, prev_out16});
            if (out_valid && out_ready) begin
                n_out16++;
                if (q16.size() == 0) begin
                    checks++;
                    $display("FAIL out16_unexpected: got Y=%h with no op outstanding", y);
                end else begin
                    e = q16.pop_front();
                    check("out16", {16'h0, y, c, v, n, z}, e);
                    $display("dut16 out #%0d Y=%h C=%b V=%b N=%b Z=%b", n_out16, y, c, v, n, z);
                end
            end
            if (in_valid && in_ready)
                q16.push_back(model(16, op, {16'h0, a}, {16'h0, b}, ci));
            prev_stall16 = out_valid && !out_ready;
            prev_out16   = {y, c, v, n, z};
        end
    end

    // Compare process for the 8-bit single-stage instance, including latency 1.
    always @(negedge clk) begin
        logic [35:0] e;
        int          t;
        if (!rst_n) begin
            q8.delete();
            q8_cyc.delete();
        end else begin
            if (s_out_valid && s_out_ready) begin
                n_out8++;
                if (q8.size() == 0) begin
                    checks++;
                    $display("FAIL out8_unexpected: got Y=%h with no op outstanding", s_y);
                end else begin
                    e = q8.pop_front();
                    t = q8_cyc.pop_front();
                    check("out8", {24'h0, s_y, s_c, s_v, s_n, s_z}, e);
                    check("lat8", 36'(cyc - t), 36'd1);
                end
            end
            if (s_in_valid && s_in_ready) begin
                q8.push_back(model(8, s_op, {24'h0, s_a}, {24'h0, s_b}, s_ci));
                q8_cyc.push_back(cyc);
            end
        end
    end

    // One op through an idle pipe: checks latency and a hand-computed result.
    task automatic run_one(input string name, input logic [1:0] o, input logic [15:0] xa,
                           input logic [15:0] xb, input logic xc, input logic [19:0] exp);
        int lat;
        in_valid = 1'b1; op = o; a = xa; b = xb; ci = xc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, 36'(lat), 36'd4);
        check(name, {16'h0, y, c, v, n, z}, {16'h0, exp});
        @(posedge clk); #1;
    endtask

    initial begin
        int g;
        int base;
        rst_n = 1'b0;
        in_valid = 0; a = 0; b = 0; ci = 0; op = 0; out_ready = 1;
        s_in_valid = 0; s_a = 0; s_b = 0; s_ci = 0; s_op = 0; s_out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset16", {15'h0, y, c, v, n, z, out_valid}, 36'h0);
        check("reset8", {23'h0, s_y, s_c, s_v, s_n, s_z, s_out_valid}, 36'h0);
        rst_n = 1'b1;
        check("in_ready_after_reset", {35'h0, in_ready}, 36'h1);

        // Directed vectors: {Y, C, V, N, Z}
        run_one("add_7fff_1",   2'b00, 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 4'b0110});
        run_one("sub_0_1",      2'b10, 16'h0000, 16'h0001, 1'b0, {16'hFFFF, 4'b0010});
        run_one("sub_8000_1",   2'b10, 16'h8000, 16'h0001, 1'b0, {16'h7FFF, 4'b1100});
        run_one("adc_ffff_0_1", 2'b01, 16'hFFFF, 16'h0000, 1'b1, {16'h0000, 4'b1001});
        run_one("sbc_1234_234", 2'b11, 16'h1234, 16'h0234, 1'b0, {16'h0FFF, 4'b1000});
        run_one("adc_00ff_0f01",2'b01, 16'h00FF, 16'h0F01, 1'b1, {16'h1001, 4'b0000});

        // 8 back-to-back random ops with out_ready low in cycles 5-7.
        base = n_out16;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    in_valid = 1'b1;
                    op = 2'($urandom_range(0, 3));
                    a  = 16'($urandom);
                    b  = 16'($urandom);
                    ci = 1'($urandom_range(0, 1));
                    g = 0;
                    @(negedge clk);
                    while (!in_ready && g < 50) begin
                        @(negedge clk);
                        g++;
                    end
                    if (!in_ready) begin
                        checks++;
                        $display("FAIL stream_accept: got in_ready=0 expected 1 within 50 cycles");
                    end
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        g = 0;
        while (q16.size() != 0 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("stream_count", 36'(n_out16 - base), 36'd8);
        check("stream_drained", 36'(q16.size()), 36'd0);

        // Two ops accepted, then an asynchronous reset pulse discards them.
        in_valid = 1'b1; op = 2'b00; a = 16'h1111; b = 16'h2222; ci = 0;
        @(posedge clk); #1;
        a = 16'h3333;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset16", {15'h0, y, c, v, n, z, out_valid}, 36'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        base = n_out16;
        repeat (6) @(posedge clk);
        #1;
        check("midreset_no_out", 36'(n_out16 - base), 36'd0);
        run_one("after_reset_add", 2'b00, 16'h0F0F, 16'h00F1, 1'b0, {16'h1000, 4'b0000});

        // SEG=1 instance: ADC over every A and CI, B striding so all values occur.
        base = n_out8;
        for (int ia = 0; ia < 256; ia++) begin
            for (int j = 0; j < 64; j++) begin
                for (int k = 0; k < 2; k++) begin
                    s_in_valid = 1'b1;
                    s_op = 2'b01;
                    s_a  = 8'(ia);
                    s_b  = 8'(j * 4 + (ia % 4));
                    s_ci = 1'(k);
                    @(posedge clk); #1;
                end
            end
            if (ia % 32 == 31) $display("dut8 ADC sweep through A=%02h", ia);
        end
        s_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sweep8_count", 36'(n_out8 - base), 36'd32768);
        check("sweep8_drained", 36'(q8.size()), 36'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
